// File: rtl/ni_flit_injector_if.sv
// Request/payload/flit/credit bundle between an endpoint and its NoC injector.
// master = injector side, slave = endpoint/router side.
interface ni_flit_injector_if #(
  parameter int V     = 4,
  parameter int Fpay  = 32,
  parameter int DSTw  = 8,
  parameter int SIZEw = 8,
  parameter int Cw    = 1
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DSTw-1:0]       req_dest;
  logic [SIZEw-1:0]      req_size;
  logic [Cw-1:0]         req_class;
  logic [Fpay-1:0]       data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [2+V+Fpay-1:0]   flit_out;
  logic                  flit_out_wr;
  logic [V-1:0]          credit_in;
  logic                  busy;

  modport master (
    input  req_valid, req_dest, req_size, req_class, data_in, data_valid, credit_in,
    output req_ready, data_ready, flit_out, flit_out_wr, busy
  );

  modport slave (
    output req_valid, req_dest, req_size, req_class, data_in, data_valid, credit_in,
    input  req_ready, data_ready, flit_out, flit_out_wr, busy
  );
endinterface

// File: rtl/ni_flit_injector.sv
// Endpoint flit injector: builds header/body/tail flits for one wormhole packet at a
// time, picks a VC per class by round-robin and tracks per-VC router credits.
module ni_flit_injector #(
  parameter int V     = 4,
  parameter int B     = 4,
  parameter int C     = 2,
  parameter int Fpay  = 32,
  parameter int DSTw  = 8,
  parameter int SIZEw = 8,
  parameter logic [C*V-1:0] CLASS_SETTING = '1
) (
  input logic                clk,
  input logic                reset,
  ni_flit_injector_if.master bus
);
  localparam int Cw  = (C > 1) ? $clog2(C) : 1;
  localparam int VCw = (V > 1) ? $clog2(V) : 1;
  localparam int CRw = $clog2(B + 1);
  localparam int Fw  = 2 + V + Fpay;

  typedef enum logic {IDLE, BODY} state_e;

  state_e           state_q, state_d;
  logic [CRw-1:0]   credit_q [V];
  logic [CRw-1:0]   credit_d [V];
  logic [VCw-1:0]   rr_q, rr_d;
  logic [V-1:0]     vc_q, vc_d;
  logic [SIZEw-1:0] rem_q, rem_d;
  logic [Fw-1:0]    flit_q, flit_d;
  logic             wr_q, wr_d;

  logic [V-1:0]     class_mask, eligible, send_vc;
  logic [VCw-1:0]   pick;
  logic             vc_has_credit, req_ready_c, data_ready_c;
  logic [SIZEw-1:0] size_eff;
  logic [Fpay-1:0]  hdr_payload;

  assign class_mask  = V'(CLASS_SETTING >> (V * int'(bus.req_class)));
  assign size_eff    = (bus.req_size == '0) ? SIZEw'(1) : bus.req_size;
  assign hdr_payload = Fpay'({bus.req_class[Cw-1:0], size_eff, bus.req_dest[DSTw-1:0]});

  always_comb begin
    eligible      = '0;
    vc_has_credit = 1'b0;
    for (int unsigned v = 0; v < V; v++) begin
      eligible[v]   = class_mask[v] && (credit_q[v] != '0);
      vc_has_credit = vc_has_credit | (vc_q[v] && (credit_q[v] != '0));
    end
  end

  // First eligible VC at or after the round-robin pointer.
  always_comb begin : rr_pick
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < V; i++) begin
      idx = (int'(rr_q) + int'(i)) % V;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = VCw'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    vc_d         = vc_q;
    rem_d        = rem_q;
    flit_d       = flit_q;
    wr_d         = 1'b0;
    send_vc      = '0;
    req_ready_c  = 1'b0;
    data_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = |eligible;
        if (bus.req_valid && (|eligible)) begin
          send_vc = V'(1) << pick;
          flit_d  = {1'b1, size_eff == SIZEw'(1), send_vc, hdr_payload};
          wr_d    = 1'b1;
          rr_d    = (pick == VCw'(V - 1)) ? '0 : pick + 1'b1;
          if (size_eff != SIZEw'(1)) begin
            rem_d   = size_eff - SIZEw'(1);
            vc_d    = send_vc;
            state_d = BODY;
          end
        end
      end
      BODY: begin
        data_ready_c = vc_has_credit;
        if (bus.data_valid && vc_has_credit) begin
          send_vc = vc_q;
          flit_d  = {1'b0, rem_q == SIZEw'(1), vc_q, bus.data_in};
          wr_d    = 1'b1;
          rem_d   = rem_q - SIZEw'(1);
          if (rem_q == SIZEw'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A send and a return on the same VC cancel; out-of-range moves saturate.
  always_comb begin
    for (int unsigned v = 0; v < V; v++) begin
      credit_d[v] = credit_q[v];
      if (bus.credit_in[v] && !send_vc[v] && (credit_q[v] != CRw'(B)))
        credit_d[v] = credit_q[v] + 1'b1;
      else if (!bus.credit_in[v] && send_vc[v] && (credit_q[v] != '0))
        credit_d[v] = credit_q[v] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      vc_q    <= '0;
      rem_q   <= '0;
      flit_q  <= '0;
      wr_q    <= 1'b0;
      for (int unsigned v = 0; v < V; v++) credit_q[v] <= CRw'(B);
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      vc_q     <= vc_d;
      rem_q    <= rem_d;
      flit_q   <= flit_d;
      wr_q     <= wr_d;
      credit_q <= credit_d;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.data_ready  = data_ready_c;
  assign bus.flit_out    = flit_q;
  assign bus.flit_out_wr = wr_q;
  assign bus.busy        = (state_q == BODY) || wr_q;

  for (genvar gv = 0; gv < V; gv++) begin : g_credit_chk
    a_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(bus.credit_in[gv] && !send_vc[gv] && (credit_q[gv] == CRw'(B))));
    a_underflow: assert property (@(posedge clk) disable iff (!reset)
      !(!bus.credit_in[gv] && send_vc[gv] && (credit_q[gv] == '0)));
  end

  a_size_zero: assert property (@(posedge clk) disable iff (!reset)
    !(bus.req_valid && req_ready_c && (bus.req_size == '0)));
endmodule

// File: tb/tb_ni_flit_injector.sv
// Bench for ni_flit_injector: packet/credit reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ni_flit_injector;
  localparam int V = 4, B = 4, C = 2, Fpay = 32, DSTw = 8, SIZEw = 8, Cw = 1;
  localparam int Fw = 2 + V + Fpay;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ni_flit_injector_if #(.V(V), .Fpay(Fpay), .DSTw(DSTw), .SIZEw(SIZEw), .Cw(Cw)) bus ();
  ni_flit_injector_if #(.V(V), .Fpay(Fpay), .DSTw(DSTw), .SIZEw(SIZEw), .Cw(Cw)) bus2 ();

  ni_flit_injector #(.V(V), .B(B), .C(C), .Fpay(Fpay), .DSTw(DSTw), .SIZEw(SIZEw),
                     .CLASS_SETTING(8'hFF)) dut (.clk(clk), .reset(reset), .bus(bus));
  ni_flit_injector #(.V(V), .B(B), .C(C), .Fpay(Fpay), .DSTw(DSTw), .SIZEw(SIZEw),
                     .CLASS_SETTING(8'hC3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int errors = 0;
  int checks = 0;

  // Reference model: credits, round-robin pointer, open packet and last flit.
  int          cr [V];
  int          rr = 0;
  bit          inpkt = 0;
  int          cur = 0;
  int          left = 0;
  logic [Fw-1:0] ef = '0;
  bit          ew = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [V-1:0] onehot(input int v);
    return V'(1 << v);
  endfunction

  function automatic logic [V-1:0] elig(input int cls);
    logic [V-1:0] e;
    for (int v = 0; v < V; v++) e[v] = (cr[v] > 0);
    if (cls >= C) e = '0;
    return e;
  endfunction

  task automatic model_step(input bit rst_n, input bit rv, input int sz, input int cls,
                            input int dst, input bit dv, input logic [31:0] d,
                            input logic [V-1:0] cin);
    int sent;
    int p;
    bit found;
    logic [V-1:0] e;
    if (!rst_n) begin
      for (int v = 0; v < V; v++) cr[v] = B;
      rr = 0; inpkt = 0; ef = '0; ew = 0;
      return;
    end
    sent = -1;
    ew = 0;
    if (!inpkt) begin
      e = elig(cls);
      if (rv && e != '0) begin
        found = 0; p = 0;
        for (int k = 0; k < V; k++)
          if (!found && e[(rr + k) % V]) begin found = 1; p = (rr + k) % V; end
        rr = (p + 1) % V;
        ef = {1'b1, 1'(sz == 1), onehot(p), 32'(dst + (sz << 8) + (cls << 16))};
        ew = 1;
        sent = p;
        if (sz > 1) begin inpkt = 1; left = sz - 1; cur = p; end
      end
    end else if (dv && cr[cur] > 0) begin
      ef = {1'b0, 1'(left == 1), onehot(cur), d};
      ew = 1;
      sent = cur;
      left--;
      if (left == 0) inpkt = 0;
    end
    for (int v = 0; v < V; v++) cr[v] = cr[v] + int'(cin[v]) - ((sent == v) ? 1 : 0);
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, check flit.
  task automatic cyc(input bit rst_n, input bit rv, input int sz, input int cls,
                     input int dst, input bit dv, input logic [31:0] d,
                     input logic [V-1:0] cin);
    reset          = rst_n;
    bus.req_valid  = rv;
    bus.req_size   = SIZEw'(sz);
    bus.req_class  = Cw'(cls);
    bus.req_dest   = DSTw'(dst);
    bus.data_valid = dv;
    bus.data_in    = d;
    bus.credit_in  = cin;
    #1;
    chk("req_ready",  64'(bus.req_ready),  64'(!inpkt && (elig(cls) != '0)));
    chk("data_ready", 64'(bus.data_ready), 64'(inpkt && cr[cur] > 0));
    chk("busy",       64'(bus.busy),       64'(inpkt || ew));
    model_step(rst_n, rv, sz, cls, dst, dv, d, cin);
    @(posedge clk);
    #1;
    chk("flit_out_wr", 64'(bus.flit_out_wr), 64'(ew));
    chk("flit_out",    64'(bus.flit_out),    64'(ef));
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1, 0, 1, 0, 0, 0, 32'h0, '0);
  endtask

  initial begin
    logic [V-1:0] cin;
    int v;
    for (int i = 0; i < V; i++) cr[i] = B;
    bus.req_valid = 0; bus.req_size = 1; bus.req_class = 0; bus.req_dest = 0;
    bus.data_valid = 0; bus.data_in = 0; bus.credit_in = 0;
    bus2.req_valid = 0; bus2.req_size = 1; bus2.req_class = 0; bus2.req_dest = 0;
    bus2.data_valid = 0; bus2.data_in = 0; bus2.credit_in = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc(0, 0, 1, 0, 0, 0, 32'h0, '0);

    chk("rst_wr",    64'(bus.flit_out_wr), 64'd0);
    chk("rst_flit",  64'(bus.flit_out),    64'd0);
    chk("rst_busy",  64'(bus.busy),        64'd0);
    chk("rst_ready", 64'(bus.req_ready),   64'd1);

    // Single-flit packet: header and tail together on VC0.
    cyc(1, 1, 1, 0, 5, 0, 32'h0, '0);
    chk("size1_flit", 64'(bus.flit_out), 64'({2'b11, 4'b0001, 32'h0000_0105}));

    // Size-4 packet lands on VC1 (pointer advanced), tail only on last word.
    cyc(1, 1, 4, 0, 8'h22, 1, 32'h0, '0);
    chk("size4_hdr", 64'(bus.flit_out), 64'({2'b10, 4'b0010, 32'h0000_0422}));
    cyc(1, 0, 1, 0, 0, 1, 32'hA, '0);
    chk("size4_b0", 64'(bus.flit_out), 64'({2'b00, 4'b0010, 32'hA}));
    cyc(1, 0, 1, 0, 0, 1, 32'hB, '0);
    cyc(1, 0, 1, 0, 0, 1, 32'hC, '0);
    chk("size4_tail", 64'(bus.flit_out), 64'({2'b01, 4'b0010, 32'hC}));
    idle();

    // Size-6 on VC0 after reset: stalls after 4 flits until a credit returns.
    cyc(0, 0, 1, 0, 0, 0, 32'h0, '0);
    cyc(1, 1, 6, 0, 9, 1, 32'h0, '0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 1, 32'h100 + i, '0);
    chk("stall_wr_prev", 64'(bus.flit_out_wr), 64'd1);
    cyc(1, 0, 1, 0, 0, 1, 32'h200, '0);
    chk("stall_wr",    64'(bus.flit_out_wr), 64'd0);
    chk("stall_ready", 64'(bus.data_ready),  64'd0);
    cyc(1, 0, 1, 0, 0, 1, 32'h200, 4'b0001);
    cyc(1, 0, 1, 0, 0, 1, 32'h200, '0);
    chk("credit_one_wr",   64'(bus.flit_out_wr), 64'd1);
    chk("credit_one_flit", 64'(bus.flit_out),    64'({2'b00, 4'b0001, 32'h200}));
    cyc(1, 0, 1, 0, 0, 1, 32'h300, '0);
    chk("credit_one_stop", 64'(bus.flit_out_wr), 64'd0);

    // Reset abandons the packet.
    cyc(0, 0, 1, 0, 0, 1, 32'h0, '0);
    chk("midrst_wr",    64'(bus.flit_out_wr), 64'd0);
    chk("midrst_ready", 64'(bus.req_ready),   64'd1);
    chk("midrst_busy",  64'(bus.busy),        64'd0);

    // Restricted class map on the second instance: class 1 alternates VC2/VC3.
    for (int k = 0; k < 8; k++) begin
      bus2.req_valid = 1; bus2.req_class = 1; bus2.req_size = 1; bus2.req_dest = DSTw'(k);
      #1;
      chk("cls_ready", 64'(bus2.req_ready), 64'd1);
      idle();
      chk("cls_vc", 64'(bus2.flit_out[Fw-1:Fpay]),
          64'({2'b11, ((k % 2) == 0) ? 4'b0100 : 4'b1000}));
    end
    bus2.req_valid = 1; bus2.req_class = 1;
    #1;
    chk("cls_exhaust", 64'(bus2.req_ready), 64'd0);
    bus2.req_class = 0;
    #1;
    chk("cls0_ready", 64'(bus2.req_ready), 64'd1);
    bus2.req_valid = 0;
    idle();

    // Randomized traffic with router-side credit returns.
    for (int n = 0; n < 3000; n++) begin
      v = $urandom_range(0, V - 1);
      cin = '0;
      if (cr[v] < B && $urandom_range(0, 2) == 0) cin = onehot(v);
      cyc($urandom_range(0, 99) != 0,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0) ? $urandom_range(7, 12) : $urandom_range(1, 6),
          $urandom_range(0, 1),
          $urandom_range(0, 255),
          $urandom_range(0, 9) < 7,
          $urandom,
          cin);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
